// File: rtl/mips_pkg.sv
// Shared MIPS core constants: datapath widths and memory-access type encodings.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] MEM_WORD = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_BYTE = 2'b10;

endpackage : mips_pkg

// File: rtl/load_align.sv
// Combinational load extraction from a big-endian, word-aligned memory word,
// plus the misaligned-load flag.
// Ports:
//   MemReadDataM  : raw word from DataMemory (byte 0 = bits [31:24])
//   off           : byte offset, ALUResultM[1:0]
//   MemTypeM      : access size (word/half/byte; 11 behaves as word)
//   LoadUnsignedM : zero-extend instead of sign-extend
//   MemtoRegM     : instruction is a load (qualifies the misalign flag)
//   LoadDataM     : aligned, extended load data
//   MisalignM     : load address not naturally aligned for its size
module load_align
  import mips_pkg::*;
(
  input  logic [DATA_W-1:0] MemReadDataM,
  input  logic [1:0]        off,
  input  logic [1:0]        MemTypeM,
  input  logic              LoadUnsignedM,
  input  logic              MemtoRegM,
  output logic [DATA_W-1:0] LoadDataM,
  output logic              MisalignM
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // Half/byte lane select; off 0 is the most significant lane.
  always_comb begin
    half_sel = off[1] ? MemReadDataM[15:0] : MemReadDataM[31:16];
    case (off)
      2'b00:   byte_sel = MemReadDataM[31:24];
      2'b01:   byte_sel = MemReadDataM[23:16];
      2'b10:   byte_sel = MemReadDataM[15:8];
      default: byte_sel = MemReadDataM[7:0];
    endcase
  end

  // Extension by access size; reserved type falls through to word.
  always_comb begin
    case (MemTypeM)
      MEM_HALF: LoadDataM = {{16{~LoadUnsignedM & half_sel[15]}}, half_sel};
      MEM_BYTE: LoadDataM = {{24{~LoadUnsignedM & byte_sel[7]}}, byte_sel};
      default:  LoadDataM = MemReadDataM;
    endcase
  end

  // Bytes can never be misaligned; reserved type is checked as word.
  always_comb begin
    case (MemTypeM)
      MEM_HALF: MisalignM = MemtoRegM & off[0];
      MEM_BYTE: MisalignM = 1'b0;
      default:  MisalignM = MemtoRegM & (off != 2'b00);
    endcase
  end

endmodule : load_align

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load alignment, result selection, W-stage
// control with stall/flush, misalign tracking and a retired-instruction count.
// Ports:
//   Clk, Reset (async, active-low)
//   M-stage inputs : ValidM, MemReadDataM, ALUResultM, PCPlus8M, WriteRegM,
//                    RegWriteM, MemtoRegM, LinkM, MemTypeM, LoadUnsignedM
//   Control        : StallW (hold), FlushW (bubble, wins over stall)
//   W-stage outputs: ResultW, WriteRegW, RegWriteW, ValidW, MisalignW,
//                    InstRetired
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned REG_AW = mips_pkg::REG_AW,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ValidM,
  input  logic [DATA_W-1:0] MemReadDataM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] PCPlus8M,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic              LinkM,
  input  logic [1:0]        MemTypeM,
  input  logic              LoadUnsignedM,
  input  logic              StallW,
  input  logic              FlushW,
  output logic [DATA_W-1:0] ResultW,
  output logic [REG_AW-1:0] WriteRegW,
  output logic              RegWriteW,
  output logic              ValidW,
  output logic              MisalignW,
  output logic [CNT_W-1:0]  InstRetired
);

  logic [DATA_W-1:0] load_data;
  logic              misalign;

  logic [DATA_W-1:0] result_d,   result_q;
  logic [REG_AW-1:0] wreg_d,     wreg_q;
  logic              regwrite_d, regwrite_q;
  logic              valid_d,    valid_q;
  logic              misalign_d, misalign_q;
  logic [CNT_W-1:0]  cnt_d,      cnt_q;

  load_align u_load_align (
    .MemReadDataM  (MemReadDataM),
    .off           (ALUResultM[1:0]),
    .MemTypeM      (MemTypeM),
    .LoadUnsignedM (LoadUnsignedM),
    .MemtoRegM     (MemtoRegM),
    .LoadDataM     (load_data),
    .MisalignM     (misalign)
  );

  // Next-state: flush clears control only, stall holds everything.
  always_comb begin
    result_d   = result_q;
    wreg_d     = wreg_q;
    regwrite_d = regwrite_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;
    cnt_d      = cnt_q;
    if (FlushW) begin
      regwrite_d = 1'b0;
      valid_d    = 1'b0;
      misalign_d = 1'b0;
    end else if (!StallW) begin
      if (LinkM)          result_d = PCPlus8M;
      else if (MemtoRegM) result_d = load_data;
      else                result_d = ALUResultM;
      wreg_d     = WriteRegM;
      // $0 is hardwired and misaligned loads must not corrupt the file.
      regwrite_d = ValidM & RegWriteM & ~misalign & (WriteRegM != '0);
      valid_d    = ValidM;
      misalign_d = ValidM & misalign;
      if (ValidM) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // W-stage register bank.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      result_q   <= '0;
      wreg_q     <= '0;
      regwrite_q <= 1'b0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      result_q   <= result_d;
      wreg_q     <= wreg_d;
      regwrite_q <= regwrite_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ResultW     = result_q;
  assign WriteRegW   = wreg_q;
  assign RegWriteW   = regwrite_q;
  assign ValidW      = valid_q;
  assign MisalignW   = misalign_q;
  assign InstRetired = cnt_q;

endmodule : mem_wb_stage

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a behavioural reference model and a
// per-cycle compare process; a second instance runs with a 4-bit counter.
module tb_mem_wb_stage;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        ValidM = 1'b0;
  logic [31:0] MemReadDataM = '0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] PCPlus8M = '0;
  logic [4:0]  WriteRegM = '0;
  logic        RegWriteM = 1'b0;
  logic        MemtoRegM = 1'b0;
  logic        LinkM = 1'b0;
  logic [1:0]  MemTypeM = '0;
  logic        LoadUnsignedM = 1'b0;
  logic        StallW = 1'b0;
  logic        FlushW = 1'b0;

  logic [31:0] ResultW;
  logic [4:0]  WriteRegW;
  logic        RegWriteW, ValidW, MisalignW;
  logic [31:0] InstRetired;

  logic [31:0] ResultW4;
  logic [4:0]  WriteRegW4;
  logic        RegWriteW4, ValidW4, MisalignW4;
  logic [3:0]  InstRetired4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  mem_wb_stage u_dut (
    .Clk(Clk), .Reset(Reset), .ValidM(ValidM), .MemReadDataM(MemReadDataM),
    .ALUResultM(ALUResultM), .PCPlus8M(PCPlus8M), .WriteRegM(WriteRegM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .LinkM(LinkM),
    .MemTypeM(MemTypeM), .LoadUnsignedM(LoadUnsignedM), .StallW(StallW),
    .FlushW(FlushW), .ResultW(ResultW), .WriteRegW(WriteRegW),
    .RegWriteW(RegWriteW), .ValidW(ValidW), .MisalignW(MisalignW),
    .InstRetired(InstRetired)
  );

  mem_wb_stage #(.CNT_W(4)) u_dut4 (
    .Clk(Clk), .Reset(Reset), .ValidM(ValidM), .MemReadDataM(MemReadDataM),
    .ALUResultM(ALUResultM), .PCPlus8M(PCPlus8M), .WriteRegM(WriteRegM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .LinkM(LinkM),
    .MemTypeM(MemTypeM), .LoadUnsignedM(LoadUnsignedM), .StallW(StallW),
    .FlushW(FlushW), .ResultW(ResultW4), .WriteRegW(WriteRegW4),
    .RegWriteW(RegWriteW4), .ValidW(ValidW4), .MisalignW(MisalignW4),
    .InstRetired(InstRetired4)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_extract(logic [31:0] w, logic [1:0] off,
                                            logic [1:0] typ, logic uns);
    logic [31:0] v;
    if (typ == 2'd1) begin
      v = (w >> (off[1] ? 0 : 16)) & 32'h0000FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF0000;
    end else if (typ == 2'd2) begin
      v = (w >> (8 * (3 - int'(off)))) & 32'h000000FF;
      if (!uns && v[7]) v = v | 32'hFFFFFF00;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic m_misal(logic ld, logic [1:0] off, logic [1:0] typ);
    if (!ld) return 1'b0;
    if (typ == 2'd2) return 1'b0;
    if (typ == 2'd1) return off[0];
    return off != 2'd0;
  endfunction

  logic [31:0] m_res;
  logic [4:0]  m_wreg;
  logic        m_rw, m_v, m_mis;
  logic [31:0] m_cnt;
  logic [3:0]  m_cnt4;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_res <= '0; m_wreg <= '0; m_rw <= 1'b0; m_v <= 1'b0; m_mis <= 1'b0;
      m_cnt <= '0; m_cnt4 <= '0;
    end else if (FlushW) begin
      m_v <= 1'b0; m_rw <= 1'b0; m_mis <= 1'b0;
    end else if (!StallW) begin
      m_res  <= LinkM ? PCPlus8M :
                MemtoRegM ? m_extract(MemReadDataM, ALUResultM[1:0], MemTypeM, LoadUnsignedM) :
                ALUResultM;
      m_wreg <= WriteRegM;
      m_v    <= ValidM;
      m_rw   <= ValidM && RegWriteM && (WriteRegM != 5'd0) &&
                !m_misal(MemtoRegM, ALUResultM[1:0], MemTypeM);
      m_mis  <= ValidM && m_misal(MemtoRegM, ALUResultM[1:0], MemTypeM);
      if (ValidM) begin
        m_cnt  <= m_cnt + 32'd1;
        m_cnt4 <= m_cnt4 + 4'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge Clk) begin
    chk("ResultW",      ResultW,             m_res);
    chk("WriteRegW",    32'(WriteRegW),      32'(m_wreg));
    chk("RegWriteW",    32'(RegWriteW),      32'(m_rw));
    chk("ValidW",       32'(ValidW),         32'(m_v));
    chk("MisalignW",    32'(MisalignW),      32'(m_mis));
    chk("InstRetired",  InstRetired,         m_cnt);
    chk("InstRetired4", 32'(InstRetired4),   32'(m_cnt4));
    chk("ValidW4",      32'(ValidW4),        32'(m_v));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_m(input logic v, input logic [31:0] rd, input logic [31:0] alu,
                       input logic [31:0] pc8, input logic [4:0] wr, input logic rw,
                       input logic m2r, input logic lnk, input logic [1:0] typ,
                       input logic uns);
    ValidM = v; MemReadDataM = rd; ALUResultM = alu; PCPlus8M = pc8;
    WriteRegM = wr; RegWriteM = rw; MemtoRegM = m2r; LinkM = lnk;
    MemTypeM = typ; LoadUnsignedM = uns;
  endtask

  logic [31:0] frz_res, frz_cnt;

  initial begin
    // reset state
    #2;
    chk("reset_ResultW", ResultW, 32'h0);
    chk("reset_InstRetired", InstRetired, 32'h0);
    tick();
    Reset = 1'b1;

    // 1: async reset between edges while ValidW=1
    set_m(1, 32'hDEADBEEF, 32'h100, 0, 5'd3, 1, 1, 0, 2'b00, 0);
    tick();
    chk("lw_pre_valid", 32'(ValidW), 32'h1);
    #2 Reset = 1'b0;
    #1;
    chk("arst_ValidW", 32'(ValidW), 32'h0);
    chk("arst_ResultW", ResultW, 32'h0);
    chk("arst_RegWriteW", 32'(RegWriteW), 32'h0);
    chk("arst_WriteRegW", 32'(WriteRegW), 32'h0);
    chk("arst_InstRetired", InstRetired, 32'h0);
    #3 Reset = 1'b1;
    tick();
    chk("post_rst_lw_Result", ResultW, 32'hDEADBEEF);
    chk("post_rst_lw_cnt", InstRetired, 32'd1);

    // 2: lb signed / unsigned
    set_m(1, 32'h12F45678, 32'h00001001, 0, 5'd8, 1, 1, 0, 2'b10, 0);
    tick();
    chk("lb_s_Result", ResultW, 32'hFFFFFFF4);
    chk("lb_s_RegWrite", 32'(RegWriteW), 32'h1);
    chk("lb_s_WriteReg", 32'(WriteRegW), 32'd8);
    LoadUnsignedM = 1'b1;
    tick();
    chk("lbu_Result", ResultW, 32'h000000F4);

    // extraction coverage across lanes
    set_m(1, 32'h8001FF7F, 32'h2000, 0, 5'd9, 1, 1, 0, 2'b01, 0); tick();
    chk("lh_off0", ResultW, 32'hFFFF8001);
    set_m(1, 32'h8001FF7F, 32'h2002, 0, 5'd9, 1, 1, 0, 2'b01, 1); tick();
    chk("lhu_off2", ResultW, 32'h0000FF7F);
    set_m(1, 32'h8001FF7F, 32'h2003, 0, 5'd9, 1, 1, 0, 2'b10, 0); tick();
    chk("lb_off3", ResultW, 32'h0000007F);
    set_m(1, 32'h8001FF7F, 32'h2002, 0, 5'd9, 1, 1, 0, 2'b10, 0); tick();
    chk("lb_off2", ResultW, 32'hFFFFFFFF);
    set_m(1, 32'hA5A5A5A5, 32'h2004, 0, 5'd9, 1, 1, 0, 2'b11, 0); tick();
    chk("type11_word", ResultW, 32'hA5A5A5A5);

    // 3: misaligned loads
    set_m(1, 32'h11223344, 32'h00000003, 0, 5'd4, 1, 1, 0, 2'b01, 0);
    frz_cnt = InstRetired;
    tick();
    chk("lh_mis_Misalign", 32'(MisalignW), 32'h1);
    chk("lh_mis_RegWrite", 32'(RegWriteW), 32'h0);
    chk("lh_mis_Valid", 32'(ValidW), 32'h1);
    chk("lh_mis_cnt", InstRetired, frz_cnt + 32'd1);
    set_m(1, 32'h11223344, 32'h00000002, 0, 5'd4, 1, 1, 0, 2'b00, 0); tick();
    chk("lw_mis_Misalign", 32'(MisalignW), 32'h1);
    set_m(0, 32'h11223344, 32'h00000002, 0, 5'd4, 1, 1, 0, 2'b00, 0); tick();
    chk("invalid_mis_clear", 32'(MisalignW), 32'h0);

    // 4: link priority and $0 writes
    set_m(1, 32'hCAFEF00D, 32'h1234, 32'h00400010, 5'd31, 1, 1, 1, 2'b00, 0); tick();
    chk("jal_Result", ResultW, 32'h00400010);
    set_m(1, 32'h0, 32'h00000007, 0, 5'd0, 1, 0, 0, 2'b00, 0); tick();
    chk("addi_r0_RegWrite", 32'(RegWriteW), 32'h0);
    chk("addi_r0_Result", ResultW, 32'h00000007);

    // 5: stall for 3 cycles with changing inputs, then stall+flush
    set_m(1, 32'h0, 32'h00000055, 0, 5'd12, 1, 0, 0, 2'b00, 0); tick();
    frz_res = ResultW;
    frz_cnt = InstRetired;
    StallW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_m(1, 32'(i), 32'h1000 + 32'(i), 32'h2000, 5'(i + 1), 1, 0, 0, 2'b00, 0);
      tick();
      chk("stall_Result", ResultW, frz_res);
      chk("stall_cnt", InstRetired, frz_cnt);
    end
    FlushW = 1'b1;
    tick();
    chk("flush_Valid", 32'(ValidW), 32'h0);
    chk("flush_RegWrite", 32'(RegWriteW), 32'h0);
    chk("flush_cnt", InstRetired, frz_cnt);
    StallW = 1'b0;
    FlushW = 1'b0;

    // 6: wrap of the 4-bit counter after 16 retirements
    @(posedge Clk); #3 Reset = 1'b0; #4 Reset = 1'b1;
    set_m(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0); tick();
    chk("bubble_no_count", InstRetired, 32'd0);
    for (int i = 0; i < 16; i++) begin
      set_m(1, 32'h0, 32'(i), 0, 5'd2, 1, 0, 0, 2'b00, 0);
      tick();
    end
    chk("wrap_cnt4", 32'(InstRetired4), 32'd0);
    chk("wrap_cnt32", InstRetired, 32'd16);
    set_m(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mem_wb_stage
